// File: rtl/ll_sync_pkg.sv
// Shared definitions for the link-layer receive strobe/marker sync checker.
package ll_sync_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_e;

    localparam int unsigned PHY_W       = 40;
    localparam int unsigned STB_BIT_DEF = 1;
    localparam int unsigned MRK_BIT_DEF = 39;

endpackage

// File: rtl/ll_rx_sync_check.sv
// Receive-side strobe/marker alignment checker: hunts for a strobe, verifies
// LOCK_COUNT periodic strobes, then counts alignment errors while locked.
module ll_rx_sync_check
    import ll_sync_pkg::*;
#(
    parameter int unsigned STB_PERIOD = 8,
    parameter int unsigned STB_BIT    = STB_BIT_DEF,
    parameter int unsigned MRK_BIT    = MRK_BIT_DEF,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic             clk_wr,
    input  logic             rst_wr_n,
    input  logic             rx_online,
    input  logic [PHY_W-1:0] rx_phy0,
    input  logic             err_clr,
    output logic             rx_sync_locked,
    output logic             rx_online_holdoff,
    output logic [15:0]      rx_sync_err_count,
    output logic [31:0]      rx_sync_debug_status
);

    localparam logic [7:0] PHASE_LAST = 8'(STB_PERIOD - 1);
    localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT   = 4'(LOSS_COUNT);

    sync_state_e state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [3:0]  consec_err_q, consec_err_d;
    logic [15:0] err_count_q, err_count_d;
    logic        locked_q, locked_d;
    logic        holdoff_q, holdoff_d;

    logic        stb, mrk, slot, good_word, good_strobe;
    logic [7:0]  phase_inc;

    always_comb begin
        stb         = rx_phy0[STB_BIT];
        mrk         = rx_phy0[MRK_BIT];
        slot        = (phase_q == PHASE_LAST);
        // A strobe is only legal in the expected slot, and is required there.
        good_word   = mrk && (stb == slot);
        good_strobe = good_word && slot;
        phase_inc   = slot ? '0 : phase_q + 8'd1;

        state_d      = state_q;
        phase_d      = phase_q;
        good_cnt_d   = good_cnt_q;
        consec_err_d = consec_err_q;
        err_count_d  = err_clr ? '0 : err_count_q;

        if (!rx_online) begin
            state_d      = ST_HUNT;
            phase_d      = '0;
            good_cnt_d   = '0;
            consec_err_d = '0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (stb && mrk) begin
                        phase_d    = '0;
                        good_cnt_d = 4'd1;
                        state_d    = (LOCK_CNT == 4'd1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    phase_d = phase_inc;
                    if (!good_word) begin
                        state_d    = ST_HUNT;
                        good_cnt_d = '0;
                    end else if (good_strobe) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_d == LOCK_CNT) state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    phase_d = phase_inc;
                    if (!good_word) begin
                        // Clear (if requested) has already been applied above.
                        if (err_count_d != '1) err_count_d = err_count_d + 16'd1;
                        consec_err_d = consec_err_q + 4'd1;
                        if (consec_err_d == LOSS_CNT) begin
                            state_d      = ST_HUNT;
                            consec_err_d = '0;
                            good_cnt_d   = '0;
                        end
                    end else if (good_strobe) begin
                        consec_err_d = '0;
                    end
                end
                default: begin
                    state_d      = ST_HUNT;
                    phase_d      = '0;
                    good_cnt_d   = '0;
                    consec_err_d = '0;
                end
            endcase
        end

        locked_d  = (state_d == ST_LOCKED);
        holdoff_d = rx_online && !locked_d;
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_q      <= ST_HUNT;
            phase_q      <= '0;
            good_cnt_q   <= '0;
            consec_err_q <= '0;
            err_count_q  <= '0;
            locked_q     <= 1'b0;
            holdoff_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            good_cnt_q   <= good_cnt_d;
            consec_err_q <= consec_err_d;
            err_count_q  <= err_count_d;
            locked_q     <= locked_d;
            holdoff_q    <= holdoff_d;
        end
    end

    assign rx_sync_locked       = locked_q;
    assign rx_online_holdoff    = holdoff_q;
    assign rx_sync_err_count    = err_count_q;
    assign rx_sync_debug_status = {12'h000, state_q, phase_q, consec_err_q, good_cnt_q, 2'b00};

endmodule

// File: tb/tb_ll_rx_sync_check.sv
// Directed self-checking bench for ll_rx_sync_check (default instance plus a
// long-period, high-loss-tolerance instance used to reach counter saturation).
module tb_ll_rx_sync_check;
    import ll_sync_pkg::*;

    logic             clk_wr = 1'b0;
    logic             rst_wr_n;
    logic             rx_online;
    logic [PHY_W-1:0] rx_phy0;
    logic             err_clr;
    logic             rx_sync_locked;
    logic             rx_online_holdoff;
    logic [15:0]      rx_sync_err_count;
    logic [31:0]      rx_sync_debug_status;

    logic             s_online;
    logic [PHY_W-1:0] s_phy;
    logic             s_clr;
    logic             s_locked;
    logic             s_holdoff;
    logic [15:0]      s_err;
    logic [31:0]      s_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_wr = ~clk_wr;

    ll_rx_sync_check u_dut (
        .clk_wr               (clk_wr),
        .rst_wr_n             (rst_wr_n),
        .rx_online            (rx_online),
        .rx_phy0              (rx_phy0),
        .err_clr              (err_clr),
        .rx_sync_locked       (rx_sync_locked),
        .rx_online_holdoff    (rx_online_holdoff),
        .rx_sync_err_count    (rx_sync_err_count),
        .rx_sync_debug_status (rx_sync_debug_status)
    );

    ll_rx_sync_check #(
        .STB_PERIOD (15),
        .LOSS_COUNT (15)
    ) u_sat (
        .clk_wr               (clk_wr),
        .rst_wr_n             (rst_wr_n),
        .rx_online            (s_online),
        .rx_phy0              (s_phy),
        .err_clr              (s_clr),
        .rx_sync_locked       (s_locked),
        .rx_online_holdoff    (s_holdoff),
        .rx_sync_err_count    (s_err),
        .rx_sync_debug_status (s_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One word on the main DUT; returns 1 time unit after the sampling edge.
    task automatic word(input logic s, input logic m, input logic clr);
        @(negedge clk_wr);
        rx_phy0          = '0;
        rx_phy0[STB_BIT_DEF] = s;
        rx_phy0[MRK_BIT_DEF] = m;
        err_clr          = clr;
        @(posedge clk_wr);
        #1;
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) word(1'b0, 1'b1, 1'b0);
    endtask

    task automatic frame();
        plain(7);
        word(1'b1, 1'b1, 1'b0);
    endtask

    task automatic sword(input logic s, input logic m, input logic clr);
        @(negedge clk_wr);
        s_phy              = '0;
        s_phy[STB_BIT_DEF] = s;
        s_phy[MRK_BIT_DEF] = m;
        s_clr              = clr;
        @(posedge clk_wr);
        #1;
    endtask

    function automatic logic [31:0] st(input logic [31:0] d);
        return 32'(d[19:18]);
    endfunction
    function automatic logic [31:0] ph(input logic [31:0] d);
        return 32'(d[17:10]);
    endfunction
    function automatic logic [31:0] ce(input logic [31:0] d);
        return 32'(d[9:6]);
    endfunction
    function automatic logic [31:0] gc(input logic [31:0] d);
        return 32'(d[5:2]);
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_wr_n  = 1'b0;
        rx_online = 1'b0;
        rx_phy0   = '0;
        err_clr   = 1'b0;
        s_online  = 1'b0;
        s_phy     = '0;
        s_clr     = 1'b0;
        repeat (3) @(posedge clk_wr);
        #1;
        chk("rst_locked",  32'(rx_sync_locked),    32'd0);
        chk("rst_holdoff", 32'(rx_online_holdoff), 32'd0);
        chk("rst_err",     32'(rx_sync_err_count), 32'd0);
        chk("rst_dbg",     rx_sync_debug_status,   32'd0);

        @(negedge clk_wr);
        rst_wr_n  = 1'b1;
        rx_online = 1'b1;
        word(1'b0, 1'b1, 1'b0);
        chk("holdoff_rise", 32'(rx_online_holdoff), 32'd1);
        chk("hunt_state",   st(rx_sync_debug_status), 32'd0);

        // Seed, then two good strobes, then a strobe at phase 5.
        word(1'b1, 1'b1, 1'b0);
        chk("seed_state", st(rx_sync_debug_status), 32'd1);
        chk("seed_good",  gc(rx_sync_debug_status), 32'd1);
        chk("seed_phase", ph(rx_sync_debug_status), 32'd0);
        plain(7);
        chk("phase_7", ph(rx_sync_debug_status), 32'd7);
        word(1'b1, 1'b1, 1'b0);
        chk("verify_good2", gc(rx_sync_debug_status), 32'd2);
        frame();
        chk("verify_good3", gc(rx_sync_debug_status), 32'd3);
        plain(5);
        word(1'b1, 1'b1, 1'b0);
        chk("break_state", st(rx_sync_debug_status), 32'd0);
        chk("break_good",  gc(rx_sync_debug_status), 32'd0);
        chk("break_phase", ph(rx_sync_debug_status), 32'd6);
        chk("break_unlocked", 32'(rx_sync_locked), 32'd0);

        // Fresh acquisition: seed plus three strobes.
        word(1'b0, 1'b1, 1'b0);
        word(1'b1, 1'b1, 1'b0);
        frame();
        frame();
        plain(7);
        chk("prelock_locked",  32'(rx_sync_locked),    32'd0);
        chk("prelock_holdoff", 32'(rx_online_holdoff), 32'd1);
        word(1'b1, 1'b1, 1'b0);
        chk("lock_locked",  32'(rx_sync_locked),         32'd1);
        chk("lock_holdoff", 32'(rx_online_holdoff),      32'd0);
        chk("lock_state",   st(rx_sync_debug_status),    32'd2);
        chk("lock_err",     32'(rx_sync_err_count),      32'd0);

        // Marker drop while locked.
        word(1'b0, 1'b0, 1'b0);
        chk("mrk_err",    32'(rx_sync_err_count),   32'd1);
        chk("mrk_locked", 32'(rx_sync_locked),      32'd1);
        chk("mrk_consec", ce(rx_sync_debug_status), 32'd1);
        plain(6);
        word(1'b1, 1'b1, 1'b0);
        chk("mrk_consec_clr", ce(rx_sync_debug_status), 32'd0);

        // Two misses then a good strobe keeps lock.
        word(1'b0, 1'b1, 1'b1);
        chk("clr_err", 32'(rx_sync_err_count), 32'd0);
        plain(6);
        word(1'b0, 1'b1, 1'b0);
        chk("miss1_err", 32'(rx_sync_err_count), 32'd1);
        plain(7);
        word(1'b0, 1'b1, 1'b0);
        chk("miss2_consec", ce(rx_sync_debug_status), 32'd2);
        frame();
        chk("miss2_locked", 32'(rx_sync_locked),      32'd1);
        chk("miss2_consec0", ce(rx_sync_debug_status), 32'd0);
        chk("miss2_err",    32'(rx_sync_err_count),   32'd2);

        // Stray strobe at phase 3 counts as error and does not re-seed.
        plain(3);
        word(1'b1, 1'b1, 1'b0);
        chk("stray_err",   32'(rx_sync_err_count),   32'd3);
        chk("stray_phase", ph(rx_sync_debug_status), 32'd4);
        plain(3);
        word(1'b1, 1'b1, 1'b0);
        chk("stray_slot_kept", ce(rx_sync_debug_status), 32'd0);

        // Three consecutive misses drop lock.
        word(1'b0, 1'b1, 1'b1);
        plain(6);
        word(1'b0, 1'b1, 1'b0);
        plain(7);
        word(1'b0, 1'b1, 1'b0);
        chk("loss2_locked", 32'(rx_sync_locked), 32'd1);
        plain(7);
        word(1'b0, 1'b1, 1'b0);
        chk("loss_err",     32'(rx_sync_err_count),    32'd3);
        chk("loss_locked",  32'(rx_sync_locked),       32'd0);
        chk("loss_holdoff", 32'(rx_online_holdoff),    32'd1);
        chk("loss_state",   st(rx_sync_debug_status),  32'd0);

        // Relock, then take the link offline.
        word(1'b1, 1'b1, 1'b0);
        frame();
        frame();
        frame();
        chk("relock_locked", 32'(rx_sync_locked), 32'd1);
        rx_online = 1'b0;
        word(1'b0, 1'b1, 1'b0);
        chk("offline_locked",  32'(rx_sync_locked),    32'd0);
        chk("offline_holdoff", 32'(rx_online_holdoff), 32'd0);
        chk("offline_err",     32'(rx_sync_err_count), 32'd3);
        chk("offline_dbg",     rx_sync_debug_status,   32'd0);
        rx_online = 1'b1;
        word(1'b0, 1'b1, 1'b0);
        chk("online_holdoff", 32'(rx_online_holdoff), 32'd1);
        word(1'b1, 1'b1, 1'b0);
        frame();
        frame();
        frame();
        chk("relock2_locked", 32'(rx_sync_locked), 32'd1);

        // Asynchronous reset between clock edges.
        #1;
        rst_wr_n = 1'b0;
        #1;
        chk("arst_locked",  32'(rx_sync_locked),    32'd0);
        chk("arst_holdoff", 32'(rx_online_holdoff), 32'd0);
        chk("arst_err",     32'(rx_sync_err_count), 32'd0);
        chk("arst_dbg",     rx_sync_debug_status,   32'd0);
        @(negedge clk_wr);
        rx_phy0  = '0;
        rst_wr_n = 1'b1;
        plain(6);
        word(1'b1, 1'b1, 1'b0);
        frame();
        frame();
        chk("post_rst_nolock", 32'(rx_sync_locked), 32'd0);
        frame();
        chk("post_rst_lock", 32'(rx_sync_locked), 32'd1);

        // Saturation on the period-15 instance: 14 errors + 1 strobe per frame.
        s_online = 1'b1;
        sword(1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 14; i++) sword(1'b0, 1'b1, 1'b0);
            sword(1'b1, 1'b1, 1'b0);
        end
        chk("sat_lock", 32'(s_locked), 32'd1);
        for (int f = 0; f < 4681; f++) begin
            for (int i = 0; i < 14; i++) sword(1'b0, 1'b0, 1'b0);
            sword(1'b1, 1'b1, 1'b0);
        end
        chk("sat_fffe", 32'(s_err), 32'h0000_FFFE);
        sword(1'b0, 1'b0, 1'b0);
        chk("sat_ffff", 32'(s_err), 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) sword(1'b0, 1'b0, 1'b0);
        chk("sat_hold",   32'(s_err),    32'h0000_FFFF);
        chk("sat_locked", 32'(s_locked), 32'd1);
        sword(1'b0, 1'b0, 1'b1);
        chk("sat_clr_err", 32'(s_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
